// File: rtl/nano_arb_pkg.sv
// rtl/nano_arb_pkg.sv - shared widths and types for the nano memory arbiter
package nano_arb_pkg;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } arb_state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/nano_mem_arbiter_if.sv
// rtl/nano_mem_arbiter_if.sv - bundle of both master ports and the memory side of the arbiter
interface nano_mem_arbiter_if;
  import nano_arb_pkg::*;

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic [DW-1:0] a_rdata;
  logic          a_rvalid;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;
  logic          b_err;

  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_dataW;
  logic [DW-1:0] mem_dataR;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_dataR,
    output a_gnt, a_rdata, a_rvalid,
    output b_gnt, b_rdata, b_rvalid, b_err,
    output mem_ce, mem_we, mem_address, mem_dataW
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_dataR,
    input  a_gnt, a_rdata, a_rvalid,
    input  b_gnt, b_rdata, b_rvalid, b_err,
    input  mem_ce, mem_we, mem_address, mem_dataW
  );

endinterface

// File: rtl/nano_arb_rr_core.sv
// rtl/nano_arb_rr_core.sv - two-port burst-limited round-robin grant FSM
module nano_arb_rr_core
  import nano_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic ck,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  output logic sel_a,
  output logic sel_b
);

  localparam logic [3:0] BMAX = 4'(MAX_BURST);

  arb_state_e state, state_nx;
  logic [3:0] burst_cnt, burst_nx;
  logic       last_b, last_b_nx;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
      last_b    <= last_b_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    burst_nx  = burst_cnt;
    last_b_nx = last_b;
    if (sel_a) begin
      burst_nx = (state != OWN_A) ? 4'd1 : (burst_cnt < BMAX) ? burst_cnt + 4'd1 : BMAX;
      state_nx = OWN_A;
    end else if (sel_b) begin
      burst_nx = (state != OWN_B) ? 4'd1 : (burst_cnt < BMAX) ? burst_cnt + 4'd1 : BMAX;
      state_nx = OWN_B;
    end else begin
      // Remember who held the bus so the next tie from idle goes the other way
      state_nx = IDLE;
      burst_nx = '0;
      if (state == OWN_A) begin
        last_b_nx = 1'b0;
      end else if (state == OWN_B) begin
        last_b_nx = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    if (rst) begin
      if (a_req && !b_req) begin
        sel_a = 1'b1;
      end else if (b_req && !a_req) begin
        sel_b = 1'b1;
      end else if (a_req && b_req) begin
        case (state)
          OWN_A:   if (burst_cnt < BMAX) sel_a = 1'b1; else sel_b = 1'b1;
          OWN_B:   if (burst_cnt < BMAX) sel_b = 1'b1; else sel_a = 1'b1;
          default: if (last_b) sel_a = 1'b1; else sel_b = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/nano_mem_arbiter.sv
// rtl/nano_mem_arbiter.sv - CPU/DMA memory arbiter top; NANO_ARB_WPROT_EN enables port B low-address write protection
module nano_mem_arbiter
  import nano_arb_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int PROT_LIMIT = 20
) (
  input  logic                ck,
  input  logic                rst,
  nano_mem_arbiter_if.slave   bus
);

  logic     sel_a;
  logic     sel_b;
  logic     prot_hit;
  mem_req_t req;

  nano_arb_rr_core #(.MAX_BURST(MAX_BURST)) u_core (
    .ck    (ck),
    .rst   (rst),
    .a_req (bus.a_req),
    .b_req (bus.b_req),
    .sel_a (sel_a),
    .sel_b (sel_b)
  );

  always_comb begin
    req = '0;
    if (sel_a) begin
      req.we    = bus.a_we;
      req.addr  = bus.a_addr;
      req.wdata = bus.a_wdata;
    end else if (sel_b) begin
      req.we    = bus.b_we;
      req.addr  = bus.b_addr;
      req.wdata = bus.b_wdata;
    end
  end

`ifdef NANO_ARB_WPROT_EN
  // A blocked write still consumes its grant so the DMA side sees normal progress
  assign prot_hit = sel_b & bus.b_we & (int'(bus.b_addr) < PROT_LIMIT);

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      bus.b_err <= 1'b0;
    end else begin
      bus.b_err <= prot_hit;
    end
  end
`else
  logic unused_prot;
  assign unused_prot = (PROT_LIMIT != 0);
  assign prot_hit    = 1'b0;
  assign bus.b_err   = 1'b0;
`endif

  assign bus.a_gnt       = sel_a;
  assign bus.b_gnt       = sel_b;
  assign bus.mem_ce      = sel_a | sel_b;
  assign bus.mem_we      = req.we & ~prot_hit;
  assign bus.mem_address = req.addr;
  assign bus.mem_dataW   = req.wdata;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
    end else begin
      bus.a_rvalid <= sel_a & ~bus.a_we;
      bus.b_rvalid <= sel_b & ~bus.b_we;
      if (sel_a && !bus.a_we) begin
        bus.a_rdata <= bus.mem_dataR;
      end
      if (sel_b && !bus.b_we) begin
        bus.b_rdata <= bus.mem_dataR;
      end
    end
  end

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// tb/tb_nano_mem_arbiter.sv - scoreboard bench for nano_mem_arbiter with a transaction-level reference model
module tb_nano_mem_arbiter;
  import nano_arb_pkg::*;

  localparam int MAXB = 4;
  localparam int PLIM = 20;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  nano_mem_arbiter_if bus ();

  nano_mem_arbiter #(.MAX_BURST(MAXB), .PROT_LIMIT(PLIM)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  assign bus.mem_dataR = mem[bus.mem_address];
  always @(posedge ck) if (bus.mem_ce && bus.mem_we) mem[bus.mem_address] <= bus.mem_dataW;

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int data;
    int due;
  } rd_t;

  rd_t qa[$];
  rd_t qb[$];

  // Reference model: who owns the bus, how long, and who held it last
  int owner, run, last_own, err_pend, a_wait, b_wait;
  int win, e_we, e_addr, e_dat;
  bit prot;

  always @(negedge ck) begin
    if (!rst) begin
      owner = 0; run = 0; last_own = 2; err_pend = 0; a_wait = 0; b_wait = 0;
      qa.delete();
      qb.delete();
    end else begin
      if (!bus.a_req && !bus.b_req)     win = 0;
      else if (bus.a_req && !bus.b_req) win = 1;
      else if (bus.b_req && !bus.a_req) win = 2;
      else if (owner == 0)              win = (last_own == 2) ? 1 : 2;
      else if (run < MAXB)              win = owner;
      else                              win = 3 - owner;
      prot = 1'b0;
`ifdef NANO_ARB_WPROT_EN
      prot = (win == 2) && bus.b_we && (int'(bus.b_addr) < PLIM);
`endif
      e_we = 0; e_addr = 0; e_dat = 0;
      if (win == 1) begin
        e_we = int'(bus.a_we); e_addr = int'(bus.a_addr); e_dat = int'(bus.a_wdata);
      end else if (win == 2) begin
        e_we = prot ? 0 : int'(bus.b_we); e_addr = int'(bus.b_addr); e_dat = int'(bus.b_wdata);
      end
      chk("a_gnt", 32'(bus.a_gnt), 32'(win == 1));
      chk("b_gnt", 32'(bus.b_gnt), 32'(win == 2));
      chk("mem_ce", 32'(bus.mem_ce), 32'(win != 0));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("mem_address", 32'(bus.mem_address), 32'(e_addr));
      chk("mem_dataW", 32'(bus.mem_dataW), 32'(e_dat));
      chk("b_err", 32'(bus.b_err), 32'(err_pend));
      err_pend = int'(prot);
      if (bus.a_req) begin
        if (bus.a_gnt) begin
          chk("a_wait_bound", 32'(a_wait <= MAXB), 32'd1);
          a_wait = 0;
        end else a_wait++;
      end
      if (bus.b_req) begin
        if (bus.b_gnt) begin
          chk("b_wait_bound", 32'(b_wait <= MAXB), 32'd1);
          b_wait = 0;
        end else b_wait++;
      end
      if (win == 1) begin
        if (!bus.a_we) qa.push_back('{int'(ref_mem[bus.a_addr]), cyc + 1});
        else ref_mem[bus.a_addr] = bus.a_wdata;
      end else if (win == 2) begin
        if (!bus.b_we) qb.push_back('{int'(ref_mem[bus.b_addr]), cyc + 1});
        else if (!prot) ref_mem[bus.b_addr] = bus.b_wdata;
      end
      if (win == 0) begin
        if (owner != 0) last_own = owner;
        owner = 0; run = 0;
      end else if (win == owner) begin
        run = (run < MAXB) ? run + 1 : MAXB;
      end else begin
        owner = win; run = 1;
      end
    end
  end

  bit  exp_av, exp_bv;
  rd_t rda, rdb;

  always @(negedge ck) begin
    if (rst) begin
      exp_av = (qa.size() > 0) && (qa[0].due == cyc);
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(exp_av));
      if (exp_av) begin
        rda = qa.pop_front();
        chk("a_rdata", 32'(bus.a_rdata), 32'(rda.data));
      end
      exp_bv = (qb.size() > 0) && (qb[0].due == cyc);
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(exp_bv));
      if (exp_bv) begin
        rdb = qb.pop_front();
        chk("b_rdata", 32'(bus.b_rdata), 32'(rdb.data));
      end
    end
  end

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge ck);
    #1 rst = 1'b1;
  endtask

  task automatic access(input bit pb, input bit we, input int addr, input logic [DW-1:0] d,
                        output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    if (pb) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = 8'(addr); bus.b_wdata = d;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = 8'(addr); bus.a_wdata = d;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ck);
      if (pb ? bus.b_gnt : bus.a_gnt) ok = 1'b1;
      else waited++;
    end
    chk(pb ? "b_grant_timeout" : "a_grant_timeout", 32'(ok), 32'd1);
    @(posedge ck);
    #1;
    if (pb) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  int  pat[12];
  int  n, gcnt;
  bit  ga, gb;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= init_val(i);
      ref_mem[i]  = init_val(i);
    end
    mem[20]     <= 16'h000A;
    ref_mem[20]  = 16'h000A;
    idle_inputs();

    // Reset with a request pending, then release
    bus.a_req = 1'b1; bus.a_addr = 8'd7;
    repeat (3) @(posedge ck);
    @(negedge ck);
    chk("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
    chk("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("rst_a_rdata", 32'(bus.a_rdata), 32'd0);
    chk("rst_b_err", 32'(bus.b_err), 32'd0);
    @(posedge ck);
    #1 rst = 1'b1;
    @(negedge ck);
    chk("rel_a_gnt", 32'(bus.a_gnt), 32'd1);
    chk("rel_mem_address", 32'(bus.mem_address), 32'd7);
    @(posedge ck);
    #1 bus.a_req = 1'b0;
    @(posedge ck);
    #1;

    // Single read of a preloaded word
    access(1'b0, 1'b0, 20, 16'h0, n);
    chk("t2_latency", 32'(n), 32'd0);
    @(negedge ck);
    chk("t2_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    chk("t2_a_rdata", 32'(bus.a_rdata), 32'h000A);
    @(posedge ck);
    #1;

    // Contention from idle with last owner B
    do_reset();
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      pat[i] = bus.a_gnt ? 1 : (bus.b_gnt ? 2 : 0);
      @(posedge ck);
      #1;
      bus.a_addr = 8'($urandom_range(0, 255));
      bus.b_addr = 8'($urandom_range(0, 255));
    end
    idle_inputs();
    for (int i = 0; i < 12; i++) chk($sformatf("t3_grant_%0d", i), 32'(pat[i]), 32'(((i / MAXB) % 2 == 0) ? 1 : 2));
    @(posedge ck);
    #1;

    // Write from B then read back from A
    access(1'b1, 1'b1, 21, 16'hABFC, n);
    access(1'b0, 1'b0, 21, 16'h0, n);
    @(negedge ck);
    chk("t4_a_rdata", 32'(bus.a_rdata), 32'hABFC);
    @(posedge ck);
    #1;

    // Lone requester keeps the bus, then B must get in immediately
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    gcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      if (bus.a_gnt) gcnt++;
      @(posedge ck);
      #1 bus.a_addr = 8'($urandom_range(0, 255));
    end
    chk("t5_a_grants", 32'(gcnt), 32'd10);
    access(1'b1, 1'b0, 33, 16'h0, n);
    chk("t5_b_latency", 32'(n <= 1), 32'd1);
    idle_inputs();
    @(posedge ck);
    #1;

`ifdef NANO_ARB_WPROT_EN
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'd5; bus.b_wdata = 16'h1234;
    @(negedge ck);
    chk("t6_b_gnt", 32'(bus.b_gnt), 32'd1);
    chk("t6_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t6_mem_ce", 32'(bus.mem_ce), 32'd1);
    @(posedge ck);
    #1 bus.b_req = 1'b0;
    @(negedge ck);
    chk("t6_b_err", 32'(bus.b_err), 32'd1);
    chk("t6_mem5", 32'(mem[5]), 32'(init_val(5)));
    @(posedge ck);
    #1;
    access(1'b1, 1'b1, 20, 16'h1234, n);
    @(negedge ck);
    chk("t6_b_err_ok", 32'(bus.b_err), 32'd0);
    chk("t6_mem20", 32'(mem[20]), 32'h1234);
    @(posedge ck);
    #1;
`endif

    // Randomised traffic with one mid-stream reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge ck);
      ga = bus.a_gnt;
      gb = bus.b_gnt;
      @(posedge ck);
      #1;
      if (c == 700) rst = 1'b0;
      if (c == 702) rst = 1'b1;
      if (!bus.a_req || ga) begin
        bus.a_req   = ($urandom_range(0, 99) < 65);
        bus.a_we    = 1'($urandom_range(0, 1));
        bus.a_addr  = 8'($urandom_range(0, 31));
        bus.a_wdata = 16'($urandom);
      end
      if (!bus.b_req || gb) begin
        bus.b_req   = ($urandom_range(0, 99) < 65);
        bus.b_we    = 1'($urandom_range(0, 1));
        bus.b_addr  = 8'($urandom_range(0, 31));
        bus.b_wdata = 16'($urandom);
      end
    end

    idle_inputs();
    repeat (3) @(negedge ck);
    chk("drain_qa", 32'(qa.size()), 32'd0);
    chk("drain_qb", 32'(qb.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("final_mem_%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
